// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: shared definitions for the memory-mapped UART console.
// Holds the shifter state encoding, the status word layout and the default
// decode addresses so the top level and any software-facing code agree.
package mmio_uart_tx_pkg;

    // Shifter states; the encoding is fixed so it can be observed in waveforms
    // and matched by the firmware-side documentation.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } txState_e;

    // Bit positions inside the 32-bit status word.
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_BUSY_BIT  = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_MSB = 15;

    // Default byte addresses decoded from the MEM-stage address.
    localparam logic [7:0] DEFAULT_TX_ADDR   = 8'hFF;
    localparam logic [7:0] DEFAULT_STAT_ADDR = 8'hFE;

    // Number of data bits per 8N1 frame.
    localparam int FRAME_DATA_BITS = 8;

    // Assemble the status word; every bit not listed here reads as zero.
    function automatic logic [31:0] packStatus(
        input logic       full,
        input logic       empty,
        input logic       ovf,
        input logic       busy,
        input logic [7:0] count
    );
        logic [31:0] word;
        word                                = '0;
        word[STAT_FULL_BIT]                 = full;
        word[STAT_EMPTY_BIT]                = empty;
        word[STAT_OVF_BIT]                  = ovf;
        word[STAT_BUSY_BIT]                 = busy;
        word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count;
        return word;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
// DEPTH must be a power of two so the pointers wrap on their own; the
// occupancy counter carries one extra bit so "full" is distinguishable.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             doPush, doPop;

    // Accept a pop only when data is present; a push into a full FIFO is
    // still accepted when a pop frees an entry on the same edge.
    always_comb begin
        doPop   = pop && !empty;
        doPush  = push && (!full || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards any queued data.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    assign dout  = mem_q[rdPtr_q];
    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped console responder on the data-memory port.
// Stores to TX_ADDR queue a character; STAT_ADDR reads a status word and a
// write with bit 2 set clears the sticky overflow flag. Queued bytes are
// sent as 8N1 frames on a registered, glitch-free tx line.
// CLKS_PER_BIT must be at least 2; FIFO_DEPTH a power of two in 2..256.
// With FIFO_DEPTH=256 the 8-bit count field wraps to 0 when full; the full
// flag still reports the condition.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TX_ADDR      = DEFAULT_TX_ADDR,
    parameter logic [7:0] STAT_ADDR    = DEFAULT_STAT_ADDR
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    input  logic        wren,
    output logic [31:0] dout,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int               FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]       LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

    txState_e         state_q, state_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic               pushReq;
    logic               statClear;
    logic               overflow;
    logic               baudTick;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [7:0]         fifoHead;
    logic [FIFO_CW-1:0] fifoCount;
    logic               unusedDinBits;

    // Only the low byte and the ovf-clear bit of the store data matter.
    assign unusedDinBits = ^din[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clock (clock),
        .clear (clear),
        .push  (pushReq),
        .din   (din[7:0]),
        .pop   (fifoPop),
        .dout  (fifoHead),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Address decode and read mux; reads never change any state.
    always_comb begin
        pushReq   = wren && (addr == TX_ADDR);
        statClear = wren && (addr == STAT_ADDR) && din[STAT_OVF_BIT];
        overflow  = pushReq && fifoFull && !fifoPop;
        sel       = (addr == TX_ADDR) || (addr == STAT_ADDR);
        dout      = '0;
        if (addr == STAT_ADDR) begin
            dout = packStatus(fifoFull, fifoEmpty, ovf_q, busy_q, 8'(fifoCount));
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (statClear) begin
            ovf_d = 1'b0;
        end
        if (overflow) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign baudTick = (baudCnt_q == BAUD_LAST);

    // Shifter next-state logic: IDLE launches a frame as soon as data is
    // queued, every other state advances on the baud tick, and STOP chains
    // straight into the next START when more data is waiting. The line and
    // busy values are derived from the next state so both come out of flops.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudTick ? '0 : baudCnt_q + CNT_W'(1);
        bitIdx_d  = bitIdx_q;
        shreg_d   = shreg_q;
        fifoPop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baudCnt_d = '0;
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shreg_d = fifoHead;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baudTick) begin
                    bitIdx_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baudTick) begin
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baudTick) begin
                    if (!fifoEmpty) begin
                        fifoPop = 1'b1;
                        shreg_d = fifoHead;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Shifter registers; reset aborts any frame and forces the line idle.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for the memory-mapped UART console.
// The reference model keeps a list of accepted characters with the edge on
// which each was pushed and the edge on which its frame starts; line level,
// busy and occupancy are computed from that timeline with plain arithmetic.
module tb_mmio_uart_tx;

    localparam int         CPB   = 4;
    localparam int         DEPTH = 8;
    localparam int         FRAME = 10 * CPB;
    localparam logic [7:0] TXA   = 8'hFF;
    localparam logic [7:0] STA   = 8'hFE;

    logic        clock = 1'b0;
    logic        clear;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        wren;
    logic [31:0] dout;
    logic        sel;
    logic        tx;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [7:0] data;
        int         pushE;
        int         startE;
    } frame_t;

    typedef struct {
        logic [7:0]  addr;
        logic        wren;
        logic [31:0] din;
        logic        expSel;
        logic [31:0] expDout;
    } decodeVec_t;

    frame_t     ents[$];
    int         lastStart;
    logic       mOvf;
    decodeVec_t vecs[8];
    logic       lineBits[10];

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (TXA),
        .STAT_ADDR    (STA)
    ) dut (
        .clock (clock),
        .clear (clear),
        .addr  (addr),
        .din   (din),
        .wren  (wren),
        .dout  (dout),
        .sel   (sel),
        .tx    (tx),
        .busy  (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void modelReset();
        ents.delete();
        lastStart = -100000;
        mOvf      = 1'b0;
    endfunction

    // Characters sitting in the FIFO after edge e.
    function automatic int occAfter(input int e);
        int n = 0;
        foreach (ents[i]) begin
            if (ents[i].pushE <= e && ents[i].startE > e) n++;
        end
        return n;
    endfunction

    function automatic bit popAt(input int e);
        foreach (ents[i]) begin
            if (ents[i].startE == e) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Line level and busy after edge e, from whichever frame covers e.
    function automatic void lineAt(input int e, output logic b, output logic t);
        int pos;
        b = 1'b0;
        t = 1'b1;
        foreach (ents[i]) begin
            if (e >= ents[i].startE && e < ents[i].startE + FRAME) begin
                pos = (e - ents[i].startE) / CPB;
                b   = 1'b1;
                if (pos == 0)      t = 1'b0;
                else if (pos <= 8) t = ents[i].data[pos-1];
                else               t = 1'b1;
            end
        end
    endfunction

    // Advance one clock edge, updating the model with the inputs presented
    // to that edge, then compare every output against the model.
    task automatic stepCheck();
        int          e;
        bit          pushReq, isFull, popNow, accept;
        frame_t      f;
        logic        eb, et;
        int          occ;
        logic [31:0] st;
        e = cyc + 1;
        if (clear === 1'b1) begin
            pushReq = wren && (addr == TXA);
            popNow  = popAt(e);
            isFull  = (occAfter(e - 1) == DEPTH);
            accept  = pushReq && (!isFull || popNow);
            if (accept) begin
                f.data    = din[7:0];
                f.pushE   = e;
                f.startE  = (e + 1 > lastStart + FRAME) ? e + 1 : lastStart + FRAME;
                lastStart = f.startE;
                ents.push_back(f);
            end
            if (wren && addr == STA && din[2]) mOvf = 1'b0;
            if (pushReq && !accept) mOvf = 1'b1;
        end else begin
            modelReset();
        end
        @(posedge clock);
        #1;
        cyc = e;
        lineAt(e, eb, et);
        occ = occAfter(e);
        st  = {16'h0, 8'(occ), 4'h0, eb, mOvf, (occ == 0), (occ == DEPTH)};
        checkOutput("tx", {31'b0, tx}, {31'b0, et});
        checkOutput("busy", {31'b0, busy}, {31'b0, eb});
        checkOutput("sel", {31'b0, sel}, {31'b0, (addr == TXA || addr == STA)});
        checkOutput("dout", dout, (addr == STA) ? st : 32'h0);
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic w, input logic [31:0] d);
        addr = a;
        wren = w;
        din  = d;
        stepCheck();
    endtask

    initial begin
        int          k;
        int          s;
        int          lowCount;
        logic [7:0]  rxByte;
        int          r;
        int          pushPct;

        vecs[0] = '{8'hFE, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0002};
        vecs[1] = '{8'hFF, 1'b0, 32'h0000_0041, 1'b1, 32'h0000_0000};
        vecs[2] = '{8'h00, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[3] = '{8'hFD, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        vecs[4] = '{8'h7F, 1'b0, 32'h1234_5678, 1'b0, 32'h0000_0000};
        vecs[5] = '{8'hFE, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0002};
        vecs[6] = '{8'hFC, 1'b1, 32'h0000_00FF, 1'b0, 32'h0000_0000};
        vecs[7] = '{8'hFE, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002};

        lineBits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset and idle.
        clear = 1'b0;
        wren  = 1'b0;
        addr  = STA;
        din   = 32'h0;
        modelReset();
        repeat (3) stepCheck();
        clear = 1'b1;
        repeat (50) stepCheck();
        checkOutput("idle_status", dout, 32'h0000_0002);
        checkOutput("idle_tx", {31'b0, tx}, 32'h1);

        // Address decode table on an idle, empty FIFO.
        for (int i = 0; i < 8; i++) begin
            addr = vecs[i].addr;
            wren = vecs[i].wren;
            din  = vecs[i].din;
            #1;
            checkOutput($sformatf("tbl_sel[%0d]", i), {31'b0, sel}, {31'b0, vecs[i].expSel});
            checkOutput($sformatf("tbl_dout[%0d]", i), dout, vecs[i].expDout);
            stepCheck();
        end
        wren = 1'b0;

        // Single character 0x41.
        applyStimulus(TXA, 1'b1, 32'h0000_0041);
        k    = cyc;
        wren = 1'b0;
        addr = STA;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                stepCheck();
                checkOutput($sformatf("char_bit[%0d]", b), {31'b0, tx}, {31'b0, lineBits[b]});
            end
        end
        checkOutput("char_busy_last", {31'b0, busy}, 32'h1);
        stepCheck();
        checkOutput("char_busy_drop", {31'b0, busy}, 32'h0);
        checkOutput("char_elapsed", cyc - k, 32'd41);
        repeat (5) stepCheck();

        // Back-to-back frames.
        applyStimulus(TXA, 1'b1, 32'h0000_0048);
        applyStimulus(TXA, 1'b1, 32'h0000_0069);
        wren     = 1'b0;
        addr     = STA;
        lowCount = 0;
        for (int i = 0; i < 79; i++) begin
            stepCheck();
            if (busy !== 1'b1 || (i >= 38 && i <= 40 && dout[15:8] === 8'd0 && i < 39)) lowCount++;
        end
        checkOutput("b2b_gap", lowCount, 32'd0);
        stepCheck();
        checkOutput("b2b_done", {31'b0, busy}, 32'h0);
        repeat (5) stepCheck();

        // Overflow: ten stores on consecutive edges.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(TXA, 1'b1, 32'h30 + i);
        end
        k    = cyc - 9;
        wren = 1'b0;
        addr = STA;
        #1;
        checkOutput("ovf_status", dout, 32'h0000_080D);
        applyStimulus(STA, 1'b1, 32'h0000_0004);
        wren = 1'b0;
        checkOutput("ovf_cleared", dout, 32'h0000_0809);

        // Push into a full FIFO on the STOP-tick edge.
        while (cyc < k + 40) stepCheck();
        applyStimulus(TXA, 1'b1, 32'h0000_007E);
        wren = 1'b0;
        addr = STA;
        #1;
        checkOutput("full_pushpop", dout, 32'h0000_0809);
        repeat (9 * FRAME + 10) stepCheck();
        checkOutput("drained", dout, 32'h0000_0002);

        // Reset in the middle of DATA bit 3 with another byte queued.
        applyStimulus(TXA, 1'b1, 32'h0000_00F0);
        s    = cyc + 1;
        wren = 1'b0;
        addr = STA;
        while (cyc < s + 4) stepCheck();
        applyStimulus(TXA, 1'b1, 32'h0000_0011);
        wren = 1'b0;
        addr = STA;
        while (cyc < s + 17) stepCheck();
        checkOutput("mid_tx_low", {31'b0, tx}, 32'h0);
        clear = 1'b0;
        modelReset();
        #1;
        checkOutput("async_tx", {31'b0, tx}, 32'h1);
        checkOutput("async_busy", {31'b0, busy}, 32'h0);
        checkOutput("async_status", dout, 32'h0000_0002);
        repeat (2) stepCheck();
        clear = 1'b1;
        repeat (3) stepCheck();
        applyStimulus(TXA, 1'b1, 32'h0000_0055);
        k      = cyc;
        wren   = 1'b0;
        addr   = STA;
        rxByte = 8'h00;
        for (int i = 0; i < FRAME + 5; i++) begin
            stepCheck();
            if (cyc - k == 3) checkOutput("rx_start", {31'b0, tx}, 32'h0);
            for (int b = 0; b < 8; b++) begin
                if (cyc - k == 1 + CPB * (1 + b) + 2) rxByte[b] = tx;
            end
            if (cyc - k == 1 + CPB * 9 + 2) checkOutput("rx_stop", {31'b0, tx}, 32'h1);
        end
        checkOutput("rx_byte", {24'b0, rxByte}, 32'h0000_0055);

        // Randomized traffic against the timeline model.
        for (int i = 0; i < 900; i++) begin
            pushPct = (i < 450) ? 9 : 2;
            r       = $urandom_range(0, 99);
            if (r < pushPct) begin
                applyStimulus(TXA, 1'b1, $urandom);
            end else if (r < pushPct + 3) begin
                applyStimulus(STA, 1'b1, $urandom);
            end else if (r < pushPct + 6) begin
                applyStimulus(8'($urandom_range(0, 253)), 1'b1, $urandom);
            end else begin
                case ($urandom_range(0, 2))
                    0:       applyStimulus(STA, 1'b0, $urandom);
                    1:       applyStimulus(TXA, 1'b0, $urandom);
                    default: applyStimulus(8'($urandom_range(0, 255)), 1'b0, $urandom);
                endcase
            end
        end
        wren = 1'b0;
        addr = STA;
        repeat (DEPTH * FRAME + 20) stepCheck();
        checkOutput("final_idle", {31'b0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
